seg7_scan_ctrl: RTL

Time-multiplexed scan controller for the 4-digit 7-segment display (D0 group). It owns the shared segment bus and cycles the anodes through the digits. Each digit gets a blanking gap before it lights, which suppresses ghosting. The current digit's nibble and decimal point are presented to the existing hex-to-segment decoder. New display values arrive over a valid/ready handshake and are committed only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seg7_scan_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for a 4-digit 7-segment
//             display. Each digit gets a BLANK slot (all anodes off, nibble
//             and decimal point already presented to the decoder) followed
//             by a SHOW slot (anode low if the digit is enabled). New
//             contents arrive over valid/ready and are committed only at
//             frame boundaries while scanning.
//  Ports    : clk, rst_n (async, active-low)
//             scan_en                      - 1 = scan, 0 = dark (IDLE)
//             load_valid/load_ready        - load handshake
//             load_value/load_en/load_dp   - offered display contents
//             digit_nib, dp_n, an_n        - registered display drive
//             frame_tick                   - pulse in first cycle after a frame
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_ctrl #(
  parameter int TICK_DIV  = 25000,
  parameter int BLANK_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_value,
  input  logic [3:0]  load_en,
  input  logic [3:0]  load_dp,
  output logic [3:0]  digit_nib,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_tick
);

  localparam int c_cnt_max = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
  localparam int c_cnt_w   = $clog2(c_cnt_max);
  localparam logic [c_cnt_w-1:0] c_tick_last  = c_cnt_w'(TICK_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_idx, w_idx_nxt;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;

  logic [15:0] r_act_value, w_act_value_nxt;
  logic [3:0]  r_act_en,    w_act_en_nxt;
  logic [3:0]  r_act_dp,    w_act_dp_nxt;
  logic [15:0] r_pnd_value;
  logic [3:0]  r_pnd_en;
  logic [3:0]  r_pnd_dp;
  logic        r_pnd_full;

  logic [3:0]  r_an_n, w_an_nxt;
  logic [3:0]  r_digit_nib;
  logic        r_dp_n;
  logic        r_frame_tick;

  logic w_accept;
  logic w_frame_end;
  logic w_commit;
  logic w_blank_entry;

  assign load_ready = ~r_pnd_full;
  assign an_n       = r_an_n;
  assign digit_nib  = r_digit_nib;
  assign dp_n       = r_dp_n;
  assign frame_tick = r_frame_tick;

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = r_cnt;
    w_act_value_nxt = r_act_value;
    w_act_en_nxt    = r_act_en;
    w_act_dp_nxt    = r_act_dp;
    w_an_nxt        = 4'hF;

    w_accept    = load_valid & ~r_pnd_full;
    // Frame end only counts when scanning continues; a stop mid-SHOW
    // produces neither a tick nor a commit.
    w_frame_end = (r_state == S_SHOW) && (r_cnt == c_tick_last) &&
                  (r_idx == 2'd3) && scan_en;
    // IDLE drains any pending entry left behind by a stop.
    w_commit    = r_pnd_full && ((r_state == S_IDLE) || w_frame_end);

    if (w_commit) begin
      w_act_value_nxt = r_pnd_value;
      w_act_en_nxt    = r_pnd_en;
      w_act_dp_nxt    = r_pnd_dp;
    end
    if (w_accept && (r_state == S_IDLE)) begin
      w_act_value_nxt = load_value;
      w_act_en_nxt    = load_en;
      w_act_dp_nxt    = load_dp;
    end

    if (!scan_en) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = 2'd0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_BLANK;
          w_idx_nxt   = 2'd0;
          w_cnt_nxt   = '0;
        end
        S_BLANK: begin
          if (r_cnt == c_blank_last) begin
            w_state_nxt = S_SHOW;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (r_cnt == c_tick_last) begin
            w_state_nxt = S_BLANK;
            w_idx_nxt   = r_idx + 2'd1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = 2'd0;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    if (w_state_nxt == S_SHOW) begin
      w_an_nxt[w_idx_nxt] = ~w_act_en_nxt[w_idx_nxt];
    end

    // Nibble/dp are latched once per digit so the decoder output settles
    // during the whole BLANK slot before the anode is driven.
    w_blank_entry = (w_state_nxt == S_BLANK) && (r_state != S_BLANK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= 2'd0;
      r_cnt        <= '0;
      r_act_value  <= 16'h0;
      r_act_en     <= 4'h0;
      r_act_dp     <= 4'h0;
      r_pnd_value  <= 16'h0;
      r_pnd_en     <= 4'h0;
      r_pnd_dp     <= 4'h0;
      r_pnd_full   <= 1'b0;
      r_an_n       <= 4'hF;
      r_digit_nib  <= 4'h0;
      r_dp_n       <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_act_value  <= w_act_value_nxt;
      r_act_en     <= w_act_en_nxt;
      r_act_dp     <= w_act_dp_nxt;
      r_an_n       <= w_an_nxt;
      r_frame_tick <= w_frame_end;

      if (w_commit) begin
        r_pnd_full <= 1'b0;
      end
      if (w_accept && (r_state != S_IDLE)) begin
        r_pnd_value <= load_value;
        r_pnd_en    <= load_en;
        r_pnd_dp    <= load_dp;
        r_pnd_full  <= 1'b1;
      end

      if (w_blank_entry) begin
        r_digit_nib <= w_act_value_nxt[{w_idx_nxt, 2'b00} +: 4];
        r_dp_n      <= ~w_act_dp_nxt[w_idx_nxt];
      end
    end
  end

endmodule
`default_nettype wire
